// File: rtl/grn_attractor_ctrl.sv
// Attractor search controller for a doubled Boolean network: the s1 copy takes two
// steps for every s0 step until the copies meet, then s1 steps alone to measure the cycle length.
module grn_attractor_ctrl #(
  parameter int unsigned NODES = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NODES-1:0] seed,
  input  logic [NODES-1:0] s0_vec,
  input  logic [NODES-1:0] s1_vec,
  input  logic [CNT_W-1:0] max_steps,
  output logic             reset_nos,
  output logic [NODES-1:0] init_state,
  output logic             start_s0,
  output logic             start_s1,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] meet_steps,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RUN_A, RUN_B, CHECK, PER_RUN, PER_CHECK, FIN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] limit;
  logic [CNT_W-1:0] meet_inc;
  logic [CNT_W-1:0] period_inc;
  logic             vec_eq;

  // Saturating counter increments
  always_comb begin
    meet_inc   = (meet_steps == CNT_MAX) ? meet_steps : meet_steps + CNT_W'(1);
    period_inc = (period == CNT_MAX) ? period : period + CNT_W'(1);
    vec_eq     = (s0_vec == s1_vec);
  end

  // Strobes are set one edge early so they are high exactly while the matching state is current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      limit      <= '0;
      reset_nos  <= 1'b0;
      start_s0   <= 1'b0;
      start_s1   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      init_state <= '0;
      meet_steps <= '0;
      period     <= '0;
    end else begin
      reset_nos <= 1'b0;
      start_s0  <= 1'b0;
      start_s1  <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            init_state <= seed;
            limit      <= (max_steps == '0) ? CNT_W'(1) : max_steps;
            done       <= 1'b0;
            timeout    <= 1'b0;
            meet_steps <= '0;
            period     <= '0;
            busy       <= 1'b1;
            reset_nos  <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= RUN_A;
        end
        RUN_A: begin
          start_s0 <= 1'b1;
          start_s1 <= 1'b1;
          state    <= RUN_B;
        end
        RUN_B: begin
          state <= CHECK;
        end
        CHECK: begin
          meet_steps <= meet_inc;
          if (vec_eq) begin
            start_s1 <= 1'b1;
            state    <= PER_RUN;
          end else if (meet_inc == limit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
          end else begin
            start_s0 <= 1'b1;
            start_s1 <= 1'b1;
            state    <= RUN_A;
          end
        end
        PER_RUN: begin
          period <= period_inc;
          state  <= PER_CHECK;
        end
        PER_CHECK: begin
          if (vec_eq) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else if (period == limit) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= FIN;
          end else begin
            start_s1 <= 1'b1;
            state    <= PER_RUN;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/grn_attractor_ctrl.md
GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- NODES, 16, number of network nodes driven and observed.
- CNT_W, 32, width of the step and period counters.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, launch one attractor search.
- seed, in, NODES, initial state vector, sampled on an accepted start.
- s0_vec, in, NODES, concatenated slow-copy (s0) outputs of all nodes.
- s1_vec, in, NODES, concatenated fast-copy (s1) outputs of all nodes.
- max_steps, in, CNT_W, step budget, sampled on an accepted start.
- reset_nos, out, 1, broadcast node load strobe.
- init_state, out, NODES, per-node load value; node i takes bit i.
- start_s0, out, 1, broadcast advance strobe for the s0 copies.
- start_s1, out, 1, broadcast advance strobe for the s1 copies.
- busy, out, 1, search in progress.
- done, out, 1, search finished.
- timeout, out, 1, step budget exhausted without a result.
- meet_steps, out, CNT_W, number of CHECK cycles until s0 equalled s1.
- period, out, CNT_W, attractor length in s1 steps.

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RUN_A, RUN_B, CHECK, PER_RUN, PER_CHECK and FIN.
REQ-004 In IDLE or FIN, start=1 SHALL register seed into init_state, register max_steps, clear done, timeout, meet_steps and period, and move to LOAD. In all other states start SHALL be ignored.
REQ-005 LOAD SHALL last 1 cycle with reset_nos=1, then move to RUN_A.
- Nodes load init_state on this edge.
- The s0 pass flag is set to 1.
REQ-006 RUN_A and RUN_B SHALL each last 1 cycle with start_s0=1 and start_s1=1.
- Over the two cycles, s1 advances 2 updates and s0 advances 1 update.
- RUN_A moves to RUN_B; RUN_B moves to CHECK.
REQ-007 CHECK SHALL drive no strobes, increment meet_steps, and then act as follows.
- If s0_vec==s1_vec: go to PER_RUN.
- Else if the incremented meet_steps equals the registered max_steps: set timeout=1 and go to FIN.
- Else: go to RUN_A.
REQ-008 PER_RUN SHALL last 1 cycle with only start_s1=1, increment period, and move to PER_CHECK.
REQ-009 PER_CHECK SHALL drive no strobes and then act as follows.
- If s1_vec==s0_vec: go to FIN.
- Else if period equals the registered max_steps: set timeout=1 and go to FIN.
- Else: go to PER_RUN.
REQ-010 On entry to FIN, done SHALL be set to 1; done, timeout, meet_steps and period SHALL hold until the next accepted start.
REQ-011 busy SHALL be 1 in every state except IDLE and FIN.
REQ-012 Strobe outputs (reset_nos, start_s0, start_s1) SHALL be registered, single-cycle, and never asserted in IDLE, CHECK, PER_CHECK or FIN.
REQ-013 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-014 max_steps=0 SHALL be treated as 1.
REQ-015 A fixed-point seed SHALL end with meet_steps=1 and period=1.
REQ-016 s0_vec and s1_vec SHALL only be compared in CHECK and PER_CHECK, one cycle after the last strobe, so node register updates are visible.

Reset
REQ-017 While rst=1, asynchronously and independent of clk, the block SHALL force the following, including mid-search.
- State returns to IDLE.
- reset_nos, start_s0, start_s1, busy, done and timeout go to 0.
- init_state, meet_steps and period go to 0.
REQ-018 After rst deasserts, the block SHALL stay in IDLE until start=1.
- The nodes still hold the state they had at reset.
- The next search reloads them via LOAD.

Verification
REQ-019 The bench SHALL cover the following directed scenarios.
- Fixed point: NODES=4, identity network, seed=4'b1010, start. Expected: one reset_nos pulse; done after LOAD, RUN_A, RUN_B, CHECK, PER_RUN, PER_CHECK (7 cycles); meet_steps=1; period=1; timeout=0.
- Oscillator: inverter network, seed=0, period-2 cycle. Expected: done=1, period=2, timeout=0; start_s0 and start_s1 each pulse twice per CHECK cycle.
- Timeout: 4-bit counter network (16-cycle) with max_steps=3. Expected: timeout=1, done=1, meet_steps=3, period=0.
- Busy start: start asserted repeatedly during RUN. Expected: no extra reset_nos; results identical to a single start.
- Mid-search reset: rst pulsed during PER_RUN. Expected: all outputs 0 within the reset cycle, IDLE held; a new start then completes normally.
- Restart from FIN: start in FIN with a new seed. Expected: done clears on the next edge and the results are recomputed.
